// File: rtl/alu_arbiter_pkg.sv
// Shared types for the round-robin ALU arbiter.
// Holds ALU op/word types, arbiter state and request bundle.
package alu_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } aluop_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  typedef struct packed {
    aluop_t aluop;
    word_t  porta;
    word_t  portb;
  } alu_req_t;

  localparam int ALU_NREQ = 2;

  // Flag vector layout: {negative, overflow, zero}
  localparam int FLAG_W = 3;

endpackage

// File: rtl/alu_arbiter_if.sv
// Port bundle of the shared ALU instance.
// alu_tb: the client side that drives operands and samples results.
interface alu_ports;
  import alu_arbiter_pkg::*;

  word_t              porta;
  word_t              portb;
  aluop_t             aluop;
  word_t              out_port;
  logic [FLAG_W-1:0]  flags;

  modport alu_tb (
    output porta,
    output portb,
    output aluop,
    input  out_port,
    input  flags
  );

  modport alu (
    input  porta,
    input  portb,
    input  aluop,
    output out_port,
    output flags
  );

endinterface

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Searches cyclically from last+1 for the first set request.
module rr_picker #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int cand;

  // First requester found after the last winner, wrapping around
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last) + k) % NREQ;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ clients.
// Optional per-client grant counters: ALU_ARB_STATS_EN.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ  = ALU_NREQ,
  parameter int CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  aluop_t [NREQ-1:0]      req_aluop,
  input  word_t [NREQ-1:0]       req_porta,
  input  word_t [NREQ-1:0]       req_portb,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output word_t                  rsp_out,
  output logic [FLAG_W-1:0]      rsp_flags,
`ifdef ALU_ARB_STATS_EN
  output logic [NREQ-1:0][CNT_W-1:0] grant_cnt,
`endif
  alu_ports.alu_tb               alu
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] pick_idx;
  logic [NREQ-1:0]  pick_gnt;
  logic             pick_any;
  logic             can_accept;
  logic             fire;
  alu_req_t         sel;

  rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req  (req_valid),
    .last (last_grant),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Result register is free, or is being drained by its owner now
  assign can_accept = !RST &&
                      ((state == IDLE) ||
                       (state == HOLD && rsp_ready[owner]));
  assign fire       = can_accept && pick_any;
  assign req_ready  = fire ? pick_gnt : '0;

  // Steer the winner's operands to the ALU, zeros otherwise
  always_comb begin
    sel = '0;
    if (fire) begin
      sel.aluop = req_aluop[pick_idx];
      sel.porta = req_porta[pick_idx];
      sel.portb = req_portb[pick_idx];
    end
  end

  assign alu.aluop = sel.aluop;
  assign alu.porta = sel.porta;
  assign alu.portb = sel.portb;

  // Arbiter FSM with the registered result and pointer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      rsp_valid  <= '0;
      rsp_out    <= '0;
      rsp_flags  <= '0;
      owner      <= '0;
      last_grant <= IDX_W'(NREQ - 1);
    end else if (fire) begin
      state      <= HOLD;
      rsp_valid  <= pick_gnt;
      rsp_out    <= alu.out_port;
      rsp_flags  <= alu.flags;
      owner      <= pick_idx;
      last_grant <= pick_idx;
    end else if (can_accept) begin
      state     <= IDLE;
      rsp_valid <= '0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Saturating count of accepted requests per client
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      grant_cnt <= '0;
    end else if (fire && grant_cnt[pick_idx] != '1) begin
      grant_cnt[pick_idx] <= grant_cnt[pick_idx] + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU.
// Build with ALU_ARB_STATS_EN to cover the grant counters.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int NREQ  = 2;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  aluop_t [NREQ-1:0]     req_aluop;
  word_t [NREQ-1:0]      req_porta;
  word_t [NREQ-1:0]      req_portb;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  word_t                 rsp_out;
  logic [2:0]            rsp_flags;
`ifdef ALU_ARB_STATS_EN
  logic [NREQ-1:0][CNT_W-1:0] grant_cnt;
`endif

  alu_ports alu_if ();

  alu_arbiter #(
    .NREQ  (NREQ),
    .CNT_W (CNT_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_aluop (req_aluop),
    .req_porta (req_porta),
    .req_portb (req_portb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_flags (rsp_flags),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt (grant_cnt),
`endif
    .alu       (alu_if)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passed = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // Reference ALU: {n, v, z, result}
  function automatic logic [34:0] alu_f(aluop_t op, word_t a, word_t b);
    word_t r;
    logic  v;
    r = '0;
    v = 1'b0;
    case (op)
      ALU_ADD: begin
        r = a + b;
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      ALU_SUB: begin
        r = a - b;
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SLL: r = a << b[4:0];
      ALU_SRL: r = a >> b[4:0];
      ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    return {r[31], v, (r == 32'd0), r};
  endfunction

  logic [34:0] alu_res;
  always_comb alu_res = alu_f(alu_if.aluop, alu_if.porta, alu_if.portb);
  assign alu_if.out_port = alu_res[31:0];
  assign alu_if.flags    = alu_res[34:32];

  // Model state: is a result held, for whom, and what it is
  logic  m_hold;
  int    m_owner;
  int    m_last;
  word_t m_out;
  logic [2:0] m_flags;
  int    m_cnt [NREQ];

  function automatic int m_pick();
    int i;
    for (int k = 1; k <= NREQ; k++) begin
      i = (m_last + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] m_ready();
    int p;
    p = m_pick();
    if (RST) return '0;
    if (m_hold && !rsp_ready[m_owner]) return '0;
    if (p < 0) return '0;
    return NREQ'(1) << p;
  endfunction

  function automatic logic [34:0] m_res();
    int p;
    p = m_pick();
    return alu_f(req_aluop[p], req_porta[p], req_portb[p]);
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_hold  <= 1'b0;
      m_owner <= 0;
      m_last  <= NREQ - 1;
      for (int i = 0; i < NREQ; i++) m_cnt[i] <= 0;
    end else if (m_ready() != '0) begin
      {m_flags, m_out} <= m_res();
      m_hold  <= 1'b1;
      m_owner <= m_pick();
      m_last  <= m_pick();
      if (m_cnt[m_pick()] < CMAX)
        m_cnt[m_pick()] <= m_cnt[m_pick()] + 1;
    end else if (!m_hold || rsp_ready[m_owner]) begin
      m_hold <= 1'b0;
    end
  end

  // Mid-cycle comparison of every output against the model
  always @(negedge CLK) begin
    chk("req_ready", req_ready, m_ready());
    chk("rsp_valid", rsp_valid,
        m_hold ? (NREQ'(1) << m_owner) : '0);
    if (m_hold) begin
      chk("rsp_out", rsp_out, m_out);
      chk("rsp_flags", rsp_flags, m_flags);
    end
`ifdef ALU_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++)
      chk("grant_cnt", grant_cnt[i], m_cnt[i]);
`endif
  end

  task automatic set_req(int i, aluop_t op, word_t a, word_t b);
    req_aluop[i] = op;
    req_porta[i] = a;
    req_portb[i] = b;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [NREQ-1:0] seq [4];
  aluop_t ops [4] = '{ALU_SLL, ALU_SRL, ALU_SLT, ALU_SUB};
  word_t  opa [4] = '{32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
  word_t  opb [4] = '{32'd31, 32'd31, 32'h1, 32'h1};

  initial begin
    RST       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, ALU_ADD, '0, '0);
    repeat (2) tick();
    @(negedge CLK);
    chk("rst_valid", rsp_valid, 2'b00);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_out", rsp_out, 32'h0);
    chk("rst_flags", rsp_flags, 3'b000);
    tick();
    RST = 1'b0;

    // Tie after reset, overflowing add
    set_req(0, ALU_ADD, 32'h7FFF_FFFF, 32'h1);
    set_req(1, ALU_SUB, 32'd5, 32'd5);
    req_valid = 2'b11;
    @(negedge CLK);
    chk("tie_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    @(negedge CLK);
    chk("add_valid", rsp_valid, 2'b01);
    chk("add_out", rsp_out, 32'h8000_0000);
    chk("add_flags", rsp_flags, 3'b110);
    chk("hold_ready", req_ready, 2'b00);
    tick();
    rsp_ready = 2'b10;
    @(negedge CLK);
    chk("nonowner_ready", req_ready, 2'b00);
    chk("nonowner_valid", rsp_valid, 2'b01);
    tick();
    rsp_ready = 2'b01;
    @(negedge CLK);
    chk("handoff_ready", req_ready, 2'b10);
    tick();

    // Zero flag, then backpressure on owner 1
    req_valid = 2'b00;
    set_req(0, ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    @(negedge CLK);
    chk("sub_valid", rsp_valid, 2'b10);
    chk("sub_out", rsp_out, 32'h0);
    chk("sub_flags", rsp_flags, 3'b001);
    tick();
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("bp_ready", req_ready, 2'b00);
      chk("bp_valid", rsp_valid, 2'b10);
      chk("bp_out", rsp_out, 32'h0);
      tick();
    end
    rsp_ready = 2'b10;
    @(negedge CLK);
    chk("bp_handoff", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    rsp_ready = 2'b01;
    set_req(1, ALU_OR, 32'h1234_0000, 32'h0000_5678);
    @(negedge CLK);
    chk("and_out", rsp_out, 32'h00F0_00F0);
    chk("and_handoff", req_ready, 2'b10);
    tick();

    // Fairness with both clients always requesting
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    set_req(0, ALU_XOR, 32'hAAAA_5555, 32'hFFFF_0000);
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      seq[c] = req_ready;
      tick();
    end
    chk("fair0", seq[0], 2'b01);
    chk("fair1", seq[1], 2'b10);
    chk("fair2", seq[2], 2'b01);
    chk("fair3", seq[3], 2'b10);

    // Back-to-back re-grants to the same client
    req_valid = 2'b01;
    for (int c = 0; c < 4; c++) begin
      set_req(0, ops[c], opa[c], opb[c]);
      @(negedge CLK);
      tick();
    end
    req_valid = 2'b00;
    @(negedge CLK);
    chk("ovf_out", rsp_out, 32'h7FFF_FFFF);
    chk("ovf_flags", rsp_flags, 3'b010);
    tick();

    // Reset while a result is held
    set_req(0, ALU_ADD, 32'd1, 32'd2);
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    tick();
    req_valid = 2'b11;
    #1 RST = 1'b1;
    #1;
    chk("rst_mid_valid", rsp_valid, 2'b00);
    chk("rst_mid_ready", req_ready, 2'b00);
    chk("rst_mid_out", rsp_out, 32'h0);
    tick();
    RST = 1'b0;
    rsp_ready = 2'b01;
    @(negedge CLK);
    chk("rst_tie", req_ready, 2'b01);
    tick();
    req_valid = 2'b01;
    repeat (4) @(posedge CLK);
    #1;
    req_valid = 2'b00;
    @(negedge CLK);
`ifdef ALU_ARB_STATS_EN
    chk("cnt0_sat", grant_cnt[0], 2'd3);
    chk("cnt1_zero", grant_cnt[1], 2'd0);
`endif
    repeat (2) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
